// File: rtl/gb_fanout_pkg.sv
// Shared decode helpers and encodings for the ghostbus fan-out router.
package gb_fanout_pkg;

    localparam int SEL_W = 5;
    // Child indices occupy 0..15; the two codes above them mark non-child reads.
    localparam logic [SEL_W-1:0] SEL_LOCAL = 5'd16;
    localparam logic [SEL_W-1:0] SEL_UNMAP = 5'd17;

    localparam logic [31:0] DEAD_VAL_DEF = 32'hDEADBEEF;
    localparam int ERRCNT_W = 16;

    typedef struct packed {
        logic       is_local;
        logic       is_child;
        logic [3:0] index;
    } page_dec_t;

    function automatic page_dec_t decode_page(input logic [63:0] addr,
                                              input int unsigned caw,
                                              input int unsigned nch);
        logic [63:0] page;
        page_dec_t   d;
        page       = addr >> caw;
        d.is_local = (page == 64'd0);
        d.is_child = (page != 64'd0) && (page <= 64'(nch));
        d.index    = 4'(page - 64'd1);
        return d;
    endfunction

endpackage

// File: rtl/gb_fanout_router_rd_pipe.sv
// Fixed-depth valid/sel/data shift line carrying in-flight reads to the return mux.
module gb_rd_pipe #(
    parameter int RD_LAT = 3,
    parameter int SW     = 5,
    parameter int DW     = 32
) (
    input  logic          gb_clk,
    input  logic          gb_rst_n,
    input  logic          in_valid,
    input  logic [SW-1:0] in_sel,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [SW-1:0] out_sel,
    output logic [DW-1:0] out_data
);

    logic [RD_LAT-1:0]    valid_reg;
    logic [RD_LAT*SW-1:0] sel_reg;
    logic [RD_LAT*DW-1:0] data_reg;

    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            valid_reg <= '0;
            sel_reg   <= '0;
            data_reg  <= '0;
        end else begin
            valid_reg <= {valid_reg[RD_LAT-2:0], in_valid};
            sel_reg   <= {sel_reg[(RD_LAT-1)*SW-1:0], in_sel};
            data_reg  <= {data_reg[(RD_LAT-1)*DW-1:0], in_data};
        end
    end

    assign out_valid = valid_reg[RD_LAT-1];
    assign out_sel   = sel_reg[(RD_LAT-1)*SW +: SW];
    assign out_data  = data_reg[(RD_LAT-1)*DW +: DW];

endmodule

// File: rtl/gb_fanout_router.sv
// Ghostbus fan-out: local CSR window plus NCH child windows, fixed-latency reads.
// Optional GB_FANOUT_ERRCNT_EN adds an unmapped-access counter at local offset NREG.
module gb_fanout_router
    import gb_fanout_pkg::*;
#(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int NCH    = 4,
    parameter int CAW    = 8,
    parameter int NREG   = 4,
    parameter int RD_LAT = 3,
    parameter logic [DW-1:0] CSR_INIT = '0,
    parameter logic [DW-1:0] DEAD_VAL = DW'(DEAD_VAL_DEF)
) (
    input  logic              gb_clk,
    input  logic              gb_rst_n,
    input  logic [AW-1:0]     gb_addr,
    input  logic [DW-1:0]     gb_wdata,
    input  logic              gb_wen,
    input  logic              gb_rstb,
    output logic [DW-1:0]     gb_rdata,
    output logic              gb_rvalid,
    output logic [CAW-1:0]    ch_addr,
    output logic [DW-1:0]     ch_wdata,
    output logic [NCH-1:0]    ch_we,
    output logic [NCH-1:0]    ch_rstb,
    input  logic [NCH*DW-1:0] ch_rdata,
    output logic [NREG*DW-1:0] csr_q
);

    localparam logic [CAW-1:0] NREG_OFF = CAW'(NREG);

    logic [CAW-1:0] offset;
    page_dec_t      dec;
    logic           csr_hit;
    logic           err_hit;
    logic           unmapped;
    logic [NCH-1:0] hit_vec;

    assign offset   = gb_addr[CAW-1:0];
    assign dec      = decode_page(64'(gb_addr), CAW, NCH);
    assign csr_hit  = dec.is_local && (offset < NREG_OFF);
`ifdef GB_FANOUT_ERRCNT_EN
    assign err_hit  = dec.is_local && (offset == NREG_OFF);
`else
    assign err_hit  = 1'b0;
`endif
    assign unmapped = !(csr_hit || err_hit || dec.is_child);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_hit
            assign hit_vec[gi] = dec.is_child && (dec.index == 4'(gi));
        end

        for (genvar gi = 0; gi < NREG; gi++) begin : g_csr
            logic [DW-1:0] csr_r;
            always_ff @(posedge gb_clk or negedge gb_rst_n) begin
                if (!gb_rst_n)
                    csr_r <= CSR_INIT;
                else if (gb_wen && csr_hit && (offset == CAW'(gi)))
                    csr_r <= gb_wdata;
            end
            assign csr_q[gi*DW +: DW] = csr_r;
        end
    endgenerate

`ifdef GB_FANOUT_ERRCNT_EN
    logic [ERRCNT_W-1:0] errcnt_reg;

    // A clear through the CSR write takes priority over a same-cycle count.
    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n)
            errcnt_reg <= '0;
        else if (gb_wen && err_hit)
            errcnt_reg <= '0;
        else if ((gb_wen || gb_rstb) && unmapped && (errcnt_reg != '1))
            errcnt_reg <= errcnt_reg + 1'b1;
    end
`endif

    // Local value is snapshotted at the sample edge, so it is always pre-write.
    logic [DW-1:0]    local_rd;
    logic [SEL_W-1:0] push_sel;

    always_comb begin
        local_rd = '0;
        for (int i = 0; i < NREG; i++)
            if (offset == CAW'(i))
                local_rd = csr_q[i*DW +: DW];
`ifdef GB_FANOUT_ERRCNT_EN
        if (err_hit)
            local_rd = DW'(errcnt_reg);
`endif
    end

    always_comb begin
        if (dec.is_child)
            push_sel = {1'b0, dec.index};
        else if (csr_hit || err_hit)
            push_sel = SEL_LOCAL;
        else
            push_sel = SEL_UNMAP;
    end

    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            ch_addr  <= '0;
            ch_wdata <= '0;
            ch_we    <= '0;
            ch_rstb  <= '0;
        end else begin
            if (gb_wen || gb_rstb) begin
                ch_addr  <= offset;
                ch_wdata <= gb_wdata;
            end
            ch_we   <= {NCH{gb_wen}} & hit_vec;
            ch_rstb <= {NCH{gb_rstb}} & hit_vec;
        end
    end

    logic             pipe_valid;
    logic [SEL_W-1:0] pipe_sel;
    logic [DW-1:0]    pipe_data;

    gb_rd_pipe #(
        .RD_LAT (RD_LAT),
        .SW     (SEL_W),
        .DW     (DW)
    ) u_rd_pipe (
        .gb_clk    (gb_clk),
        .gb_rst_n  (gb_rst_n),
        .in_valid  (gb_rstb),
        .in_sel    (push_sel),
        .in_data   (local_rd),
        .out_valid (pipe_valid),
        .out_sel   (pipe_sel),
        .out_data  (pipe_data)
    );

    logic [DW-1:0] rd_mux;

    always_comb begin
        rd_mux = DEAD_VAL;
        if (pipe_sel == SEL_LOCAL)
            rd_mux = pipe_data;
        else
            for (int k = 0; k < NCH; k++)
                if (pipe_sel == SEL_W'(k))
                    rd_mux = ch_rdata[k*DW +: DW];
    end

    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            gb_rvalid <= 1'b0;
            gb_rdata  <= '0;
        end else begin
            gb_rvalid <= pipe_valid;
            if (pipe_valid)
                gb_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_gb_fanout_router.sv
// Scoreboard bench for gb_fanout_router; honours GB_FANOUT_ERRCNT_EN when defined.
module tb_gb_fanout_router;

    localparam int AW = 24, DW = 32, NCH = 4, CAW = 8, NREG = 4, RD_LAT = 3;

    logic              gb_clk;
    logic              gb_rst_n;
    logic [AW-1:0]     gb_addr;
    logic [DW-1:0]     gb_wdata;
    logic              gb_wen;
    logic              gb_rstb;
    logic [DW-1:0]     gb_rdata;
    logic              gb_rvalid;
    logic [CAW-1:0]    ch_addr;
    logic [DW-1:0]     ch_wdata;
    logic [NCH-1:0]    ch_we;
    logic [NCH-1:0]    ch_rstb;
    logic [NCH*DW-1:0] ch_rdata;
    logic [NREG*DW-1:0] csr_q;

    gb_fanout_router #(
        .AW(AW), .DW(DW), .NCH(NCH), .CAW(CAW), .NREG(NREG), .RD_LAT(RD_LAT)
    ) dut (
        .gb_clk    (gb_clk),
        .gb_rst_n  (gb_rst_n),
        .gb_addr   (gb_addr),
        .gb_wdata  (gb_wdata),
        .gb_wen    (gb_wen),
        .gb_rstb   (gb_rstb),
        .gb_rdata  (gb_rdata),
        .gb_rvalid (gb_rvalid),
        .ch_addr   (ch_addr),
        .ch_wdata  (ch_wdata),
        .ch_we     (ch_we),
        .ch_rstb   (ch_rstb),
        .ch_rdata  (ch_rdata),
        .csr_q     (csr_q)
    );

    initial gb_clk = 1'b0;
    always #5 gb_clk = ~gb_clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          cyc = 0;
    logic [31:0] csr_m [NREG];
    logic [15:0] err_m;

    always @(posedge gb_clk) cyc <= cyc + 1;

    initial begin
        for (int k = 0; k < NCH; k++)
            ch_rdata[k*DW +: DW] = 32'h1000 + 32'(k);
    end

    function automatic logic model_unmapped(input logic [23:0] a);
        if (a[23:8] == 16'd0 && a[7:0] < 8'(NREG)) return 1'b0;
`ifdef GB_FANOUT_ERRCNT_EN
        if (a[23:8] == 16'd0 && a[7:0] == 8'(NREG)) return 1'b0;
`endif
        if (a[23:8] >= 16'd1 && a[23:8] <= 16'(NCH)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_read(input logic [23:0] a);
        if (a[23:8] == 16'd0 && a[7:0] < 8'(NREG)) return csr_m[a[1:0]];
`ifdef GB_FANOUT_ERRCNT_EN
        if (a[23:8] == 16'd0 && a[7:0] == 8'(NREG)) return {16'h0, err_m};
`endif
        if (a[23:8] >= 16'd1 && a[23:8] <= 16'(NCH)) return 32'h1000 + 32'(a[23:8]) - 32'd1;
        return 32'hDEADBEEF;
    endfunction

    function automatic logic [NREG*DW-1:0] csr_vec();
        logic [NREG*DW-1:0] v;
        for (int i = 0; i < NREG; i++) v[i*DW +: DW] = csr_m[i];
        return v;
    endfunction

    // Return monitor: every gb_rvalid pops the scoreboard and checks data and arrival cycle.
    always @(negedge gb_clk) begin
        if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
            chk_cnt++;
            $display("FAIL rd_missing: no gb_rvalid by cycle %0d, required data %h", sb_q[0].due, sb_q[0].data);
            void'(sb_q.pop_front());
        end
        if (gb_rvalid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL rd_unexpected: gb_rvalid=1 data=%h at cycle %0d, required no return", gb_rdata, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk_cnt += 2;
                if (gb_rdata !== mon_e.data)
                    $display("FAIL rd_data: got %h, required %h", gb_rdata, mon_e.data);
                else
                    pass_cnt++;
                if (cyc != mon_e.due)
                    $display("FAIL rd_latency: returned at cycle %0d, required %0d", cyc, mon_e.due);
                else
                    pass_cnt++;
                $display("read return data=%h cycle=%0d", gb_rdata, cyc);
            end
        end
    end

    task automatic drive(input logic wen, input logic rstb, input logic [23:0] a, input logic [31:0] d);
        exp_t n;
        @(negedge gb_clk);
        gb_wen   = wen;
        gb_rstb  = rstb;
        gb_addr  = a;
        gb_wdata = d;
        if (rstb) begin
            n.data = model_read(a);
            n.due  = cyc + RD_LAT + 1;
            sb_q.push_back(n);
        end
        if ((wen || rstb) && model_unmapped(a) && err_m != 16'hFFFF) err_m = err_m + 16'd1;
        if (wen && a[23:8] == 16'd0 && a[7:0] < 8'(NREG)) csr_m[a[1:0]] = d;
`ifdef GB_FANOUT_ERRCNT_EN
        if (wen && a == 24'(NREG)) err_m = 16'd0;
`endif
        $display("drive wen=%0b rstb=%0b addr=%h wdata=%h", wen, rstb, a, d);
    endtask

    task automatic idle();
        @(negedge gb_clk);
        gb_wen  = 1'b0;
        gb_rstb = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge gb_clk);
        chk_cnt++;
        if (sb_q.size() != 0) begin
            $display("FAIL drain: %0d reads outstanding, required 0", sb_q.size());
            sb_q.delete();
        end else pass_cnt++;
    endtask

    task automatic test_reset();
        gb_rst_n = 1'b0;
        gb_wen = 1'b0; gb_rstb = 1'b0; gb_addr = '0; gb_wdata = '0;
        for (int i = 0; i < NREG; i++) csr_m[i] = 32'h0;
        err_m = 16'h0;
        repeat (2) @(negedge gb_clk);
        chk_cnt += 6;
        if (gb_rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b, required 0", gb_rvalid); else pass_cnt++;
        if (gb_rdata !== 32'h0) $display("FAIL reset_rdata: got %h, required 0", gb_rdata); else pass_cnt++;
        if (ch_we !== 4'h0 || ch_rstb !== 4'h0) $display("FAIL reset_strobes: we=%b rstb=%b, required 0", ch_we, ch_rstb); else pass_cnt++;
        if (ch_addr !== 8'h0) $display("FAIL reset_ch_addr: got %h, required 0", ch_addr); else pass_cnt++;
        if (ch_wdata !== 32'h0) $display("FAIL reset_ch_wdata: got %h, required 0", ch_wdata); else pass_cnt++;
        if (csr_q !== csr_vec()) $display("FAIL reset_csr: got %h, required %h", csr_q, csr_vec()); else pass_cnt++;
        $display("reset checked");
        gb_rst_n = 1'b1;
    endtask

    task automatic test_csr_rw();
        drive(1'b1, 1'b0, 24'h000002, 32'h12345678);
        idle();
        chk_cnt++;
        if (csr_q[95:64] !== 32'h12345678) $display("FAIL csr2_q: got %h, required 12345678", csr_q[95:64]); else pass_cnt++;
        drive(1'b0, 1'b1, 24'h000002, 32'h0);
        idle();
        wait_drain();
        drive(1'b1, 1'b0, 24'h000000, 32'hCAFEF00D);
        drive(1'b1, 1'b0, 24'h000003, 32'h0BADF00D);
        drive(1'b0, 1'b1, 24'h000000, 32'h0);
        drive(1'b0, 1'b1, 24'h000003, 32'h0);
        drive(1'b0, 1'b1, 24'h000001, 32'h0);
        idle();
        wait_drain();
        chk_cnt++;
        if (csr_q !== csr_vec()) $display("FAIL csr_all: got %h, required %h", csr_q, csr_vec()); else pass_cnt++;
    endtask

    task automatic test_child_write();
        drive(1'b1, 1'b0, 24'h000300, 32'h000000A5);
        idle();
        chk_cnt += 4;
        if (ch_we !== 4'b0100) $display("FAIL cw_we: got %b, required 0100", ch_we); else pass_cnt++;
        if (ch_addr !== 8'h00) $display("FAIL cw_addr: got %h, required 00", ch_addr); else pass_cnt++;
        if (ch_wdata !== 32'hA5) $display("FAIL cw_wdata: got %h, required 000000a5", ch_wdata); else pass_cnt++;
        if (ch_rstb !== 4'b0000) $display("FAIL cw_rstb: got %b, required 0000", ch_rstb); else pass_cnt++;
        idle();
        chk_cnt += 2;
        if (ch_we !== 4'b0000) $display("FAIL cw_we_drop: got %b, required 0000", ch_we); else pass_cnt++;
        if (csr_q !== csr_vec()) $display("FAIL cw_csr: got %h, required %h", csr_q, csr_vec()); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < NCH; k++) begin
            drive(1'b0, 1'b1, 24'((k + 1) << 8), 32'h0);
            if (k > 0) begin
                chk_cnt++;
                if (ch_rstb !== 4'(1 << (k - 1)))
                    $display("FAIL b2b_rstb%0d: got %b, required %b", k - 1, ch_rstb, 4'(1 << (k - 1)));
                else pass_cnt++;
            end
        end
        idle();
        chk_cnt++;
        if (ch_rstb !== 4'b1000) $display("FAIL b2b_rstb3: got %b, required 1000", ch_rstb); else pass_cnt++;
        wait_drain();
    endtask

    task automatic test_unmapped();
        drive(1'b0, 1'b1, 24'h000500, 32'h0);
        idle();
        chk_cnt++;
        if (ch_rstb !== 4'b0000) $display("FAIL um_rstb: got %b, required 0000", ch_rstb); else pass_cnt++;
        drive(1'b0, 1'b1, 24'h000004, 32'h0);
        drive(1'b1, 1'b0, 24'h000500, 32'h55);
        idle();
        chk_cnt += 2;
        if (ch_we !== 4'b0000) $display("FAIL um_we: got %b, required 0000", ch_we); else pass_cnt++;
        if (csr_q !== csr_vec()) $display("FAIL um_csr: got %h, required %h", csr_q, csr_vec()); else pass_cnt++;
        drive(1'b0, 1'b1, 24'h000004, 32'h0);
        drive(1'b1, 1'b0, 24'h000004, 32'h0);
        drive(1'b0, 1'b1, 24'h000004, 32'h0);
        idle();
        wait_drain();
    endtask

    task automatic test_same_cycle();
        drive(1'b1, 1'b1, 24'h000001, 32'h77);
        drive(1'b0, 1'b1, 24'h000001, 32'h0);
        idle();
        wait_drain();
        drive(1'b1, 1'b1, 24'h000205, 32'h9);
        idle();
        chk_cnt += 2;
        if (ch_we !== 4'b0010 || ch_rstb !== 4'b0010)
            $display("FAIL sc_strobes: we=%b rstb=%b, required 0010/0010", ch_we, ch_rstb);
        else pass_cnt++;
        if (ch_addr !== 8'h05) $display("FAIL sc_addr: got %h, required 05", ch_addr); else pass_cnt++;
        wait_drain();
    endtask

    task automatic test_reset_mid_read();
        int seen;
        drive(1'b0, 1'b1, 24'h000002, 32'h0);
        drive(1'b0, 1'b1, 24'h000001, 32'h0);
        @(negedge gb_clk);
        gb_wen = 1'b0; gb_rstb = 1'b0;
        gb_rst_n = 1'b0;
        sb_q.delete();
        for (int i = 0; i < NREG; i++) csr_m[i] = 32'h0;
        err_m = 16'h0;
        @(negedge gb_clk);
        gb_rst_n = 1'b1;
        chk_cnt += 3;
        if (gb_rdata !== 32'h0) $display("FAIL rmr_rdata: got %h, required 0", gb_rdata); else pass_cnt++;
        if (csr_q !== csr_vec()) $display("FAIL rmr_csr: got %h, required %h", csr_q, csr_vec()); else pass_cnt++;
        if (ch_rstb !== 4'b0000) $display("FAIL rmr_rstb: got %b, required 0000", ch_rstb); else pass_cnt++;
        seen = 0;
        repeat (8) begin
            @(negedge gb_clk);
            if (gb_rvalid === 1'b1) seen++;
        end
        chk_cnt++;
        if (seen != 0) $display("FAIL rmr_rvalid: %0d returns after reset, required 0", seen); else pass_cnt++;
        drive(1'b1, 1'b0, 24'h000003, 32'h00005A5A);
        drive(1'b0, 1'b1, 24'h000003, 32'h0);
        drive(1'b0, 1'b1, 24'h000002, 32'h0);
        idle();
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_csr_rw();
        test_child_write();
        test_back_to_back();
        test_unmapped();
        test_same_cycle();
        test_reset_mid_read();
        repeat (2) @(negedge gb_clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
